// File: rtl/dense_mac_engine.sv
// Dense (fully connected) layer MAC engine.
// Walks output neurons in groups of LANES: for each group it streams every
// input activation against the group's packed weights, adds the packed
// biases, then writes each valid lane (optional ReLU, saturated) to the
// output buffer. Buffers are external with combinational read.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, reluEn       pass request, ReLU mode (sampled with start)
//   busy, done, ovf     status: not idle, one-cycle completion, sticky saturation
//   inAdr/inData        input activation buffer read
//   weightAdr/weightData packed weight LUT read (LANES words per address)
//   biasAdr/biasData    packed bias LUT read (LANES words per address)
//   outAdr/outData/outWe output buffer write port
module dense_mac_engine #(
  parameter int unsigned IN_COUNT  = 1600,
  parameter int unsigned OUT_COUNT = 10,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned FRAC_SIZE = 30,
  parameter int unsigned LANES     = 2,
  parameter int unsigned ACC_SIZE  = 2 * DATA_SIZE + 12,
  localparam int unsigned GROUPS = (OUT_COUNT + LANES - 1) / LANES,
  localparam int unsigned IW = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1,
  localparam int unsigned OW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1,
  localparam int unsigned WW = (GROUPS * IN_COUNT > 1) ? $clog2(GROUPS * IN_COUNT) : 1,
  localparam int unsigned BW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         reluEn,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf,
  output logic [IW-1:0]                inAdr,
  input  logic [DATA_SIZE-1:0]         inData,
  output logic [WW-1:0]                weightAdr,
  input  logic [LANES*DATA_SIZE-1:0]   weightData,
  output logic [BW-1:0]                biasAdr,
  input  logic [LANES*DATA_SIZE-1:0]   biasData,
  output logic [OW-1:0]                outAdr,
  output logic [DATA_SIZE-1:0]         outData,
  output logic                         outWe
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PW = 2 * DATA_SIZE;
  localparam int unsigned TW = ACC_SIZE - DATA_SIZE + 1;

  typedef enum logic [2:0] {IDLE, MAC, BIAS, WRITE, DONE} state_t;

  state_t state, nextState;

  logic [LW-1:0]               laneK;
  logic                        reluLat;
  logic signed [ACC_SIZE-1:0]  acc     [LANES];
  logic signed [PW-1:0]        prodFull[LANES];
  logic signed [ACC_SIZE-1:0]  prodExt [LANES];
  logic signed [ACC_SIZE-1:0]  biasExt [LANES];
  logic signed [ACC_SIZE-1:0]  sel;
  logic signed [ACC_SIZE-1:0]  relued;
  logic [TW-1:0]               top;
  logic                        satFlag;
  logic                        lastIn, lastLane, lastGroup;

  // Iteration end conditions; a lane is the last one either at the lane
  // limit or at the final neuron of a partially filled group.
  assign lastIn    = (inAdr == IW'(IN_COUNT - 1));
  assign lastLane  = (laneK == LW'(LANES - 1)) || (outAdr == OW'(OUT_COUNT - 1));
  assign lastGroup = (biasAdr == BW'(GROUPS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (start) nextState = MAC;
      MAC:   if (lastIn) nextState = BIAS;
      BIAS:  nextState = WRITE;
      WRITE: if (lastLane) nextState = lastGroup ? DONE : MAC;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    outWe = 1'b0;
    case (state)
      IDLE:  ;
      MAC:   busy = 1'b1;
      BIAS:  busy = 1'b1;
      WRITE: begin busy = 1'b1; outWe = 1'b1; end
      DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Per-lane scaled product (floor shift) and bias, sign-extended to the accumulator
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      prodFull[j] = PW'($signed(inData)) * PW'($signed(weightData[j*DATA_SIZE +: DATA_SIZE]));
      prodExt[j]  = ACC_SIZE'(prodFull[j] >>> FRAC_SIZE);
      biasExt[j]  = ACC_SIZE'($signed(biasData[j*DATA_SIZE +: DATA_SIZE]));
    end
  end

  // Output post-processing of the selected lane: ReLU, then saturate
  always_comb begin
    sel = '0;
    for (int j = 0; j < LANES; j++) begin
      if (laneK == LW'(j)) sel = acc[j];
    end
    relued  = (reluLat && sel[ACC_SIZE-1]) ? '0 : sel;
    top     = relued[ACC_SIZE-1:DATA_SIZE-1];
    satFlag = !((&top) || !(|top));
    outData = relued[DATA_SIZE-1:0];
    if (satFlag) begin
      outData = relued[ACC_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                   : {1'b0, {(DATA_SIZE-1){1'b1}}};
    end
  end

  // Counters, address registers and accumulators. weightAdr and outAdr run
  // continuously across groups, so they always equal g*IN_COUNT+i and g*LANES+k.
  always_ff @(posedge clk) begin
    if (rst) begin
      inAdr     <= '0;
      weightAdr <= '0;
      biasAdr   <= '0;
      outAdr    <= '0;
      laneK     <= '0;
      reluLat   <= 1'b0;
      ovf       <= 1'b0;
      for (int j = 0; j < LANES; j++) acc[j] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          inAdr     <= '0;
          weightAdr <= '0;
          biasAdr   <= '0;
          outAdr    <= '0;
          laneK     <= '0;
          reluLat   <= reluEn;
          ovf       <= 1'b0;
          for (int j = 0; j < LANES; j++) acc[j] <= '0;
        end
        MAC: begin
          inAdr     <= lastIn ? '0 : inAdr + IW'(1);
          weightAdr <= weightAdr + WW'(1);
          for (int j = 0; j < LANES; j++) acc[j] <= acc[j] + prodExt[j];
        end
        BIAS: begin
          laneK <= '0;
          for (int j = 0; j < LANES; j++) acc[j] <= acc[j] + biasExt[j];
        end
        WRITE: begin
          if (satFlag) ovf <= 1'b1;
          outAdr <= outAdr + OW'(1);
          laneK  <= laneK + LW'(1);
          if (lastLane) begin
            laneK   <= '0;
            inAdr   <= '0;
            biasAdr <= biasAdr + BW'(1);
            for (int j = 0; j < LANES; j++) acc[j] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_mac_engine.sv
// Bench for dense_mac_engine with IN_COUNT=4, OUT_COUNT=3, LANES=2,
// DATA_SIZE=16, FRAC_SIZE=8: directed table, random passes against an
// arithmetic reference, start-ignore and mid-pass reset sequences.
module tb_dense_mac_engine;

  localparam int IN_C  = 4;
  localparam int OUT_C = 3;
  localparam int LN    = 2;
  localparam int GR    = 2;
  localparam int PASS_LEN = GR * (IN_C + 1) + OUT_C + 1;

  logic        clk = 1'b0;
  logic        rst, start, reluEn;
  logic        busy, done, ovf, outWe;
  logic [1:0]  inAdr;
  logic [15:0] inData;
  logic [2:0]  weightAdr;
  logic [31:0] weightData;
  logic [0:0]  biasAdr;
  logic [31:0] biasData;
  logic [1:0]  outAdr;
  logic [15:0] outData;

  logic [15:0] inMem [IN_C];
  logic [31:0] wMem  [GR*IN_C];
  logic [31:0] bMem  [GR];

  assign inData     = inMem[inAdr];
  assign weightData = wMem[weightAdr];
  assign biasData   = bMem[biasAdr];

  dense_mac_engine #(
    .IN_COUNT(IN_C), .OUT_COUNT(OUT_C), .DATA_SIZE(16), .FRAC_SIZE(8), .LANES(LN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .reluEn(reluEn),
    .busy(busy), .done(done), .ovf(ovf),
    .inAdr(inAdr), .inData(inData),
    .weightAdr(weightAdr), .weightData(weightData),
    .biasAdr(biasAdr), .biasData(biasData),
    .outAdr(outAdr), .outData(outData), .outWe(outWe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [1:0]  wrAdr  [$];
  logic [15:0] wrData [$];
  logic [15:0] expOut [OUT_C];
  logic        expOvf;

  always @(negedge clk) begin
    if (outWe) begin
      wrAdr.push_back(outAdr);
      wrData.push_back(outData);
    end
  end

  typedef struct {
    logic [15:0] inV;
    logic [15:0] wV;
    logic [15:0] bV;
    logic        relu;
    logic [15:0] expV;
    logic        expOvf;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fillUniform(input logic [15:0] inV, input logic [15:0] wV, input logic [15:0] bV);
    for (int i = 0; i < IN_C; i++) inMem[i] = inV;
    for (int a = 0; a < GR*IN_C; a++) wMem[a] = {wV, wV};
    for (int g = 0; g < GR; g++) bMem[g] = {bV, bV};
  endtask

  // Reference model: per-neuron arithmetic straight from the memories.
  task automatic computeExpected(input logic relu);
    expOvf = 1'b0;
    for (int n = 0; n < OUT_C; n++) begin
      int g;
      int j;
      longint accv;
      logic [31:0] wWord;
      logic [31:0] bWord;
      g = n / LN;
      j = n % LN;
      accv = 0;
      for (int i = 0; i < IN_C; i++) begin
        longint a;
        longint w;
        wWord = wMem[g*IN_C + i];
        a = longint'($signed(inMem[i]));
        w = longint'($signed(wWord[j*16 +: 16]));
        accv += (a * w) >>> 8;
      end
      bWord = bMem[g];
      accv += longint'($signed(bWord[j*16 +: 16]));
      if (relu && accv < 0) accv = 0;
      if (accv > 32767) begin accv = 32767; expOvf = 1'b1; end
      else if (accv < -32768) begin accv = -32768; expOvf = 1'b1; end
      expOut[n] = 16'(accv);
    end
  endtask

  // One full pass: start, length, write order/data, ovf, done pulse width.
  task automatic runAndCheck(input string tag, input logic relu);
    int cyc;
    wrAdr.delete();
    wrData.delete();
    @(negedge clk);
    start = 1'b1;
    reluEn = relu;
    @(posedge clk); #1;
    start = 1'b0;
    reluEn = 1'b0;
    cyc = 1;
    check({tag, " busyAtStart"}, longint'(busy), 1);
    check({tag, " ovfCleared"}, longint'(ovf), 0);
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " passLen"}, longint'(cyc), longint'(PASS_LEN));
    check({tag, " nWrites"}, longint'(wrAdr.size()), longint'(OUT_C));
    for (int n = 0; n < OUT_C; n++) begin
      if (n < wrAdr.size()) begin
        check($sformatf("%s adr%0d", tag, n), longint'(wrAdr[n]), longint'(n));
        check($sformatf("%s data%0d", tag, n), longint'(wrData[n]), longint'(expOut[n]));
      end
    end
    check({tag, " ovf"}, longint'(ovf), longint'(expOvf));
    @(posedge clk); #1;
    check({tag, " donePulse"}, longint'(done), 0);
    check({tag, " idleBusy"}, longint'(busy), 0);
    check({tag, " ovfHold"}, longint'(ovf), longint'(expOvf));
  endtask

  initial begin
    int dn;
    int nBefore;

    tbl[0] = '{16'h0100, 16'h0080, 16'h0040, 1'b0, 16'h0240, 1'b0};
    tbl[1] = '{16'h0100, 16'hFF80, 16'h0040, 1'b0, 16'hFE40, 1'b0};
    tbl[2] = '{16'h0100, 16'hFF80, 16'h0040, 1'b1, 16'h0000, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 1'b1};
    tbl[4] = '{16'h8000, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b1};
    tbl[5] = '{16'h8000, 16'h7FFF, 16'h0000, 1'b1, 16'h0000, 1'b0};
    tbl[6] = '{16'h0100, 16'h0080, 16'h0040, 1'b0, 16'h0240, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    reluEn = 1'b0;
    fillUniform(16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset ovf", longint'(ovf), 0);
    check("reset outWe", longint'(outWe), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int t = 0; t < 7; t++) begin
      fillUniform(tbl[t].inV, tbl[t].wV, tbl[t].bV);
      for (int n = 0; n < OUT_C; n++) expOut[n] = tbl[t].expV;
      expOvf = tbl[t].expOvf;
      runAndCheck($sformatf("tbl%0d", t), tbl[t].relu);
    end

    // Random passes against the reference
    for (int r = 0; r < 10; r++) begin
      logic relu;
      for (int i = 0; i < IN_C; i++)
        inMem[i] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      for (int a = 0; a < GR*IN_C; a++)
        wMem[a] = (r % 2 == 0) ? $urandom : {16'($urandom_range(0, 1023)) - 16'd512,
                                              16'($urandom_range(0, 1023)) - 16'd512};
      for (int g = 0; g < GR; g++) bMem[g] = $urandom;
      relu = 1'($urandom);
      computeExpected(relu);
      runAndCheck($sformatf("rnd%0d", r), relu);
    end

    // Start pulses in MAC and in the DONE cycle must be ignored
    fillUniform(16'h0100, 16'h0080, 16'h0040);
    wrAdr.delete();
    wrData.delete();
    dn = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) dn++;
      if (c == 16) check("ign busyAfterDone", longint'(busy), 0);
      start = (c == 2 || c == 3 || done);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ign doneCount", longint'(dn), 1);
    check("ign nWrites", longint'(wrAdr.size()), longint'(OUT_C));
    for (int n = 0; n < OUT_C; n++)
      if (n < wrData.size()) check($sformatf("ign data%0d", n), longint'(wrData[n]), 64'h0240);

    // Reset at the second MAC cycle of group 1 (cycle 9 of the pass)
    wrAdr.delete();
    wrData.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("rst preBusy", longint'(busy), 1);
    nBefore = wrAdr.size();
    check("rst group0Writes", longint'(nBefore), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst busy", longint'(busy), 0);
    check("rst outWe", longint'(outWe), 0);
    check("rst done", longint'(done), 0);
    check("rst ovf", longint'(ovf), 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst noWrites", longint'(wrAdr.size()), longint'(nBefore));
    for (int n = 0; n < OUT_C; n++) expOut[n] = 16'h0240;
    expOvf = 1'b0;
    runAndCheck("afterRst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
